// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with one split/resume slot; registered outputs, decisions visible next cycle.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (adds timeout_flag output).
module serial_bus_arbiter #(
  parameter int MASTER_NO     = 2,
  parameter int SLAVE_NO      = 3,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MASTER_NO-1:0]         bus_req,
  input  logic [MASTER_NO-1:0]         bus_util,
  input  logic [SLAVE_NO-1:0]          s_split,
  input  logic [SLAVE_NO-1:0]          s_resume,
  output logic [MASTER_NO-1:0]         bus_grant,
  output logic [MASTER_NO-1:0]         split_en,
  output logic [$clog2(MASTER_NO)-1:0] grant_id,
  output logic                         split_pending,
`ifdef ARB_TIMEOUT_EN
  output logic                         timeout_flag,
`endif
  output logic                         arb_busy
);

  localparam int GW = $clog2(MASTER_NO);
  localparam int SW = (SLAVE_NO > 1) ? $clog2(SLAVE_NO) : 1;
  localparam logic [MASTER_NO-1:0] ONE = {{(MASTER_NO-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]           r_state;
  logic [MASTER_NO-1:0] r_grant;
  logic [MASTER_NO-1:0] r_split_en;
  logic [GW-1:0]        r_gid;
  logic [GW-1:0]        r_last;
  logic [GW-1:0]        r_split_master;
  logic [SW-1:0]        r_split_slave;
  logic                 r_split_pending;

  logic [MASTER_NO-1:0] w_elig;
  logic                 w_rr_found;
  logic [GW-1:0]        w_rr_idx;
  logic [SW-1:0]        w_split_idx;
  logic                 w_util_w;
  logic                 w_req_w;
  logic                 w_resume;
  logic                 w_resume_rdy;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  assign timeout_flag = r_timeout;
`endif

  // The suspended master may not win arbitration until its split is resumed.
  assign w_elig       = bus_req & ~(r_split_pending ? (ONE << r_split_master) : '0);
  assign w_util_w     = bus_util[r_gid];
  assign w_req_w      = bus_req[r_gid];
  assign w_resume     = |r_split_en;
  assign w_resume_rdy = s_resume[r_split_slave];

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = MASTER_NO; i >= 1; i--) begin
      if (w_elig[(int'(r_last) + i) % MASTER_NO]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = GW'((int'(r_last) + i) % MASTER_NO);
      end
    end
  end

  always_comb begin
    w_split_idx = '0;
    for (int j = SLAVE_NO - 1; j >= 0; j--) begin
      if (s_split[j]) w_split_idx = SW'(j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_grant         <= '0;
      r_split_en      <= '0;
      r_gid           <= '0;
      r_last          <= GW'(MASTER_NO - 1);
      r_split_master  <= '0;
      r_split_slave   <= '0;
      r_split_pending <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt           <= '0;
      r_timeout       <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (r_split_pending && w_resume_rdy) begin
            r_grant    <= ONE << r_split_master;
            r_split_en <= ONE << r_split_master;
            r_gid      <= r_split_master;
            r_state    <= ST_GRANT;
          end else if (w_rr_found) begin
            r_grant <= ONE << w_rr_idx;
            r_gid   <= w_rr_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_util_w) begin
            r_state <= ST_BUSY;
          end else if (!w_resume && !w_req_w) begin
            r_grant <= '0;
            r_last  <= r_gid;
            r_state <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == CW'(GRANT_TIMEOUT - 1)) begin
            r_grant    <= '0;
            r_split_en <= '0;
            r_last     <= r_gid;
            r_state    <= ST_IDLE;
            r_timeout  <= 1'b1;
            if (w_resume) r_split_pending <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_BUSY: begin
          // A split outranks a simultaneous bus_util fall.
          if ((|s_split) && !w_resume && !r_split_pending) begin
            r_split_master  <= r_gid;
            r_split_slave   <= w_split_idx;
            r_split_pending <= 1'b1;
            r_grant         <= '0;
            r_last          <= r_gid;
            r_state         <= ST_IDLE;
          end else if (!w_util_w) begin
            r_grant    <= '0;
            r_split_en <= '0;
            r_last     <= r_gid;
            r_state    <= ST_IDLE;
            if (w_resume) r_split_pending <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_grant    <= '0;
          r_split_en <= '0;
        end
      endcase
    end
  end

  assign bus_grant     = r_grant;
  assign split_en      = r_split_en;
  assign grant_id      = r_gid;
  assign split_pending = r_split_pending;
  assign arb_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against an ownership-level model of the arbitration rules.
module tb_serial_bus_arbiter;
  localparam int MN = 2;
  localparam int NS = 3;
  localparam int GT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MN-1:0] bus_req = '0;
  logic [MN-1:0] bus_util = '0;
  logic [NS-1:0] s_split = '0;
  logic [NS-1:0] s_resume = '0;
  logic [MN-1:0] bus_grant;
  logic [MN-1:0] split_en;
  logic [$clog2(MN)-1:0] grant_id;
  logic          split_pending;
  logic          arb_busy;
`ifdef ARB_TIMEOUT_EN
  logic          timeout_flag;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  serial_bus_arbiter #(.MASTER_NO(MN), .SLAVE_NO(NS), .GRANT_TIMEOUT(GT)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_util(bus_util),
    .s_split(s_split), .s_resume(s_resume), .bus_grant(bus_grant),
    .split_en(split_en), .grant_id(grant_id), .split_pending(split_pending),
`ifdef ARB_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the bus, whether the owner has started using it, and the split slot.
  int m_owner, m_last, m_gid, m_sm, m_ss, m_tcnt;
  bit m_used, m_resume, m_sp, m_tflag;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = MN - 1; m_gid = 0; m_sm = 0; m_ss = 0;
      m_used = 0; m_resume = 0; m_sp = 0; m_tcnt = 0; m_tflag = 0;
    end else begin
      m_tflag = 0;
      if (m_owner < 0) begin
        if (m_sp && s_resume[m_ss]) begin
          m_owner = m_sm; m_gid = m_sm; m_resume = 1; m_used = 0; m_tcnt = 0;
        end else begin
          bit found;
          found = 0;
          for (int i = 1; i <= MN; i++) begin
            int c;
            c = (m_last + i) % MN;
            if (!found && bus_req[c] && !(m_sp && c == m_sm)) begin
              found = 1; m_owner = c; m_gid = c; m_resume = 0; m_used = 0; m_tcnt = 0;
            end
          end
        end
      end else if (!m_used) begin
        if (bus_util[m_owner]) m_used = 1;
        else if (!m_resume && !bus_req[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end else begin
          m_tcnt++;
`ifdef ARB_TIMEOUT_EN
          if (m_tcnt == GT) begin
            m_tflag = 1;
            if (m_resume) m_sp = 0;
            m_resume = 0; m_last = m_owner; m_owner = -1;
          end
`endif
        end
      end else begin
        if (s_split != 0 && !m_resume && !m_sp) begin
          int low;
          low = 0;
          for (int j = NS - 1; j >= 0; j--) if (s_split[j]) low = j;
          m_sp = 1; m_sm = m_owner; m_ss = low; m_last = m_owner; m_owner = -1;
        end else if (!bus_util[m_owner]) begin
          if (m_resume) m_sp = 0;
          m_resume = 0; m_last = m_owner; m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_grant", bus_grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("m_split_en", split_en, (m_owner >= 0 && m_resume) ? (32'd1 << m_owner) : 32'd0);
      chk("m_grant_id", grant_id, m_gid);
      chk("m_split_pending", split_pending, m_sp);
      chk("m_arb_busy", arb_busy, m_owner >= 0);
`ifdef ARB_TIMEOUT_EN
      chk("m_timeout_flag", timeout_flag, m_tflag);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [MN-1:0] rr_exp [4];
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_grant", bus_grant, 0);
    chk("rst_split_en", split_en, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_split_pending", split_pending, 0);
    chk("rst_arb_busy", arb_busy, 0);

    // Single request, five cycles of use.
    bus_req = 2'b01; tick();
    chk("single_grant", bus_grant, 2'b01);
    chk("single_id", grant_id, 0);
    chk("single_busy", arb_busy, 1);
    bus_util = 2'b01;
    repeat (5) begin tick(); chk("single_hold", bus_grant, 2'b01); end
    bus_util = 2'b00; bus_req = 2'b00; tick();
    chk("single_drop", bus_grant, 0);
    tick();
    chk("single_idle", bus_grant, 0);

    // Round robin with both masters requesting.
    bus_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 4 && bus_grant == 0; t++) tick();
      chk("rr_grant", bus_grant, rr_exp[k]);
      bus_util = bus_grant;
      repeat (3) tick();
      bus_util = 2'b00; tick();
      chk("rr_gap", bus_grant, 0);
    end

    // Split of master0 while master1 waits.
    bus_req = 2'b01; tick();
    chk("split_pre_grant", bus_grant, 2'b01);
    bus_req = 2'b11; bus_util = 2'b01; tick();
    s_split = 3'b010; tick();
    s_split = 3'b000; bus_util = 2'b00;
    chk("split_drop", bus_grant, 0);
    chk("split_pending", split_pending, 1);
    tick();
    chk("split_other_grant", bus_grant, 2'b10);
    bus_util = 2'b10; tick(); tick();
    bus_util = 2'b00; bus_req = 2'b01; tick();
    repeat (3) begin tick(); chk("split_m0_blocked", bus_grant, 0); end

    // Resume beats master1's new request.
    bus_req = 2'b11; s_resume = 3'b010; tick();
    chk("resume_grant", bus_grant, 2'b01);
    chk("resume_split_en", split_en, 2'b01);
    s_resume = 3'b000; bus_util = 2'b01; bus_req = 2'b00; tick(); tick();
    bus_util = 2'b00; tick();
    chk("resume_done_pending", split_pending, 0);
    chk("resume_done_split_en", split_en, 0);
    chk("resume_done_grant", bus_grant, 0);

    // Reset while busy with a split pending.
    bus_req = 2'b10; tick();
    chk("rst_seq_grant1", bus_grant, 2'b10);
    bus_util = 2'b10; tick();
    s_split = 3'b001; tick();
    s_split = 3'b000; bus_util = 2'b00; bus_req = 2'b01; tick();
    chk("rst_seq_grant0", bus_grant, 2'b01);
    bus_util = 2'b01; tick();
    chk("rst_seq_pending", split_pending, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", bus_grant, 0);
    chk("async_split_en", split_en, 0);
    chk("async_grant_id", grant_id, 0);
    chk("async_pending", split_pending, 0);
    chk("async_busy", arb_busy, 0);
    #1 rst = 1'b0; bus_util = 2'b00; bus_req = 2'b10;
    @(negedge clk);
    chk("post_rst_grant", bus_grant, 2'b10);
    chk("post_rst_id", grant_id, 1);
    bus_req = 2'b00; tick();
    chk("post_rst_drop", bus_grant, 0);

`ifdef ARB_TIMEOUT_EN
    bus_req = 2'b10; tick();
    bus_req = 2'b11;
    repeat (15) tick();
    chk("to_still_granted", bus_grant, 2'b10);
    tick();
    chk("to_flag", timeout_flag, 1);
    chk("to_drop", bus_grant, 0);
    tick();
    chk("to_flag_clear", timeout_flag, 0);
    chk("to_next", bus_grant, 2'b01);
    bus_req = 2'b00; tick(); tick();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < MN; m++) begin
        if ($urandom_range(0, 3) == 0) bus_req[m] = ~bus_req[m];
        if (bus_grant[m]) bus_util[m] = ($urandom_range(0, 5) != 0);
        else bus_util[m] = ($urandom_range(0, 15) == 0);
      end
      s_split = ($urandom_range(0, 9) == 0) ? NS'($urandom_range(1, (1 << NS) - 1)) : '0;
      for (int s = 0; s < NS; s++) s_resume[s] = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
